// File: rtl/bank_pkg.sv
// rtl/bank_pkg.sv - shared register-bank constants and read FSM state type
package bank_pkg;

  localparam int NUM_REGS = 14;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_t;

endpackage

// File: rtl/bank_rd_mux.sv
// rtl/bank_rd_mux.sv - combinational bank register select with out-of-range flag
module bank_rd_mux
  import bank_pkg::*;
(
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]               addr,
  output logic [DATA_W-1:0]               data,
  output logic                            oor
);

  // Unmatched addresses fall through to zero data with oor still set.
  always_comb begin
    data = '0;
    oor  = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) begin
        data = regs[i];
        oor  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bank_reader.sv
// rtl/bank_reader.sv - single/burst reader over the bank registers with a registered valid/ready output slot
module bank_reader
  import bank_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  input  logic [DATA_W-1:0] in8,
  input  logic [DATA_W-1:0] in9,
  input  logic [DATA_W-1:0] in10,
  input  logic [DATA_W-1:0] in11,
  input  logic [DATA_W-1:0] in12,
  input  logic [DATA_W-1:0] in13,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_burst,
  input  logic [ADDR_W-1:0] rd_last_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              out_last,
  output logic              busy
);

  rd_state_t                      state;
  logic [ADDR_W-1:0]              cur;
  logic [ADDR_W-1:0]              last;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [ADDR_W-1:0]              mux_addr;
  logic [DATA_W-1:0]              mux_data;
  logic                           mux_oor;
  logic                           slot_free;
  logic                           accept;
  logic                           illegal;

  assign regs = {in13, in12, in11, in10, in9, in8, in7,
                 in6, in5, in4, in3, in2, in1, in0};

  assign slot_free = !out_valid || out_ready;
  assign rd_ready  = (state == IDLE) && slot_free;
  assign accept    = rd_valid && rd_ready;
  assign illegal   = rd_burst && (rd_last_addr < rd_addr);
  assign busy      = (state != IDLE) || out_valid;
  assign mux_addr  = (state == BURST) ? cur : rd_addr;

  bank_rd_mux u_mux (
    .regs (regs),
    .addr (mux_addr),
    .data (mux_data),
    .oor  (mux_oor)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur       <= '0;
      last      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_err   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      // A drained beat empties the slot unless a new beat is loaded on the same edge.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_addr  <= rd_addr;
            if (illegal) begin
              out_data <= '0;
              out_err  <= 1'b1;
              out_last <= 1'b1;
            end else begin
              out_data <= mux_data;
              out_err  <= mux_oor;
              out_last <= !rd_burst || (rd_addr == rd_last_addr);
              if (rd_burst && (rd_addr != rd_last_addr)) begin
                state <= BURST;
                cur   <= rd_addr + ADDR_W'(1);
                last  <= rd_last_addr;
              end
            end
          end
        end
        BURST: begin
          if (slot_free) begin
            out_valid <= 1'b1;
            out_addr  <= cur;
            out_data  <= mux_data;
            out_err   <= mux_oor;
            out_last  <= (cur == last);
            if (cur == last) begin
              state <= IDLE;
            end else begin
              cur <= cur + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bank_reader.md
Name: bank_reader

Overview:
- Read-side counterpart of the register-bank write demux: selects one of the 14 bank registers by 4-bit address and returns its contents.
- Presents data on a registered valid/ready output with per-beat error flagging.
- Supports single reads and ascending burst reads (start..last address).
- Sits between the bank registers and any consumer (debug port, serializer, ALU operand fetch).

Parameters:
- NUM_REGS, 14, number of bank registers (addresses 0..NUM_REGS-1 valid).
- DATA_W, 16, register data width.
- ADDR_W, 4, address width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in0..in13  in  DATA_W each  current contents of bank registers 0..13.
- rd_valid  in  1  read request present.
- rd_ready  out  1  request accepted this cycle when rd_valid && rd_ready.
- rd_addr  in  ADDR_W  start address.
- rd_burst  in  1  0 = single read, 1 = burst read.
- rd_last_addr  in  ADDR_W  final address of burst; ignored when rd_burst=0.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat when out_valid && out_ready.
- out_data  out  DATA_W  read data.
- out_addr  out  ADDR_W  address of this beat.
- out_err  out  1  beat address out of range or illegal burst.
- out_last  out  1  final beat of the request.
- busy  out  1  state != IDLE or out_valid.

Behaviour:
- Reset (async, any time, including mid-burst):
  - State = IDLE.
  - out_valid, out_data, out_addr, out_err, out_last = 0; internal counters = 0.
  - Pending beats are discarded.
- Output slot: a single register. slot_free = !out_valid || out_ready.
  - out_* fields stay stable while out_valid=1 and out_ready=0.
- State IDLE:
  - rd_ready = slot_free.
  - Single accept (rd_burst=0): next cycle out_valid=1, out_data = in[rd_addr] sampled at the accepting edge, out_addr = rd_addr, out_last = 1. Latency is 1 cycle; state stays IDLE.
  - Burst accept, rd_last_addr >= rd_addr: first beat loaded as for single, with out_last = (rd_addr == rd_last_addr). If more beats remain, go to BURST with cur = rd_addr+1 and last = rd_last_addr.
  - Burst accept, rd_last_addr < rd_addr: one beat with out_err=1, out_data=0, out_addr=rd_addr, out_last=1; stay in IDLE.
- State BURST:
  - rd_ready = 0.
  - On each slot_free cycle, load beat cur: out_data = in[cur] sampled at that edge, out_addr = cur, out_last = (cur == last), then cur++.
  - When the beat with cur == last is loaded, return to IDLE.
  - With out_ready held at 1, throughput is one beat per cycle.
  - cur never exceeds last (at most 15), so the counter never wraps.
- Address range: any beat with address >= NUM_REGS gives out_data = 0 and out_err = 1. The burst continues after an error beat.
- Back-to-back singles: while the current beat drains (out_ready=1), rd_ready stays 1, so one request per cycle is sustained.
- Simultaneous drain and load: the new beat overwrites the slot on the same edge. No bubble and no beat loss.
- busy is combinational from registered state.

Decomposition:
- Package bank_pkg:
  - NUM_REGS, DATA_W, ADDR_W constants.
  - rd_state_t enum {IDLE, BURST}.
  - This package is shared with the write demux.
- Sub-module bank_rd_mux: combinational NUM_REGS:1 select. Returns data and an out-of-range flag; data is zero when out of range. It is instantiated once, driven by the IDLE-accept address or cur.

Test Plan:
- Single read:
  - Stimulus: in5=16'hA5A5; rd_addr=5, rd_burst=0, out_ready=1.
  - Response: next cycle out_valid=1, out_data=A5A5, out_addr=5, out_last=1, out_err=0; rd_ready stays 1.
- Burst with stall:
  - Stimulus: in2..in4 = 0x0002, 0x0003, 0x0004; burst 2..4; out_ready low for 3 cycles after the first beat.
  - Response: beat addr 2 held stable while stalled. Then beats 3 and 4 arrive on consecutive cycles; out_last only on addr 4; rd_ready=0 until the burst is done.
- Out of range:
  - Stimulus: burst 12..15.
  - Response: beats 12 and 13 return data with err=0. Beats 14 and 15 return data=0 with err=1. out_last on 15.
- Illegal burst:
  - Stimulus: rd_addr=9, rd_last_addr=3, rd_burst=1.
  - Response: single beat err=1, data=0, addr=9, last=1; state stays IDLE.
- Reset mid-burst:
  - Stimulus: burst 0..13; assert reset asynchronously after beat 4.
  - Response: out_valid=0 and busy=0 immediately. After release, a new single read of addr 0 completes normally.
- Back-to-back singles:
  - Stimulus: addresses 1, 2, 3 on consecutive cycles, out_ready=1.
  - Response: three consecutive valid beats with matching data and no gaps.
